// File: rtl/reorder_buffer_pkg.sv
// rtl/reorder_buffer_pkg.sv - shared types, sizes and tag arithmetic for the reorder buffer
package reorder_buffer_pkg;

    localparam int ROB_SIZE   = 16;
    localparam int ROB_IDX_W  = 4;
    localparam int ROB_USABLE = ROB_SIZE - 1;

    typedef logic [ROB_IDX_W-1:0] rob_idx_t;
    typedef logic [4:0]           reg_idx_t;
    typedef logic [31:0]          data_t;
    typedef logic [31:0]          addr_t;

    // Tag 0 means "no dependency", so the first real slot is 1.
    localparam rob_idx_t ROB_FIRST_TAG = rob_idx_t'(1);

    // Circular increment over 1..15; slot 0 is never handed out.
    function automatic rob_idx_t rob_idx_next(input rob_idx_t idx);
        return (idx == rob_idx_t'(ROB_USABLE)) ? ROB_FIRST_TAG : idx + rob_idx_t'(1);
    endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// rtl/reorder_buffer_if.sv - issue, broadcast, operand-query and commit signals of the reorder buffer
interface reorder_buffer_if;
    import reorder_buffer_pkg::*;

    logic     issue_ready;
    reg_idx_t issue_rd;
    logic     issue_is_branch;
    logic     issue_pred_jump;
    addr_t    issue_pc;
    rob_idx_t rob_next_index;
    logic     rob_full;

    logic     ex_valid;
    rob_idx_t ex_rob_index;
    data_t    ex_val;
    logic     ex_jump;
    addr_t    ex_jump_pc;

    rob_idx_t dc_rs1_depend;
    rob_idx_t dc_rs2_depend;
    logic     rob_rs1_ready;
    logic     rob_rs2_ready;
    data_t    rob_rs1_val;
    data_t    rob_rs2_val;

    logic     rob_to_reg_commit;
    rob_idx_t rob_to_reg_rob_index;
    reg_idx_t rob_to_reg_index;
    data_t    rob_to_reg_val;
    logic     rob_clr_out;
    addr_t    rob_target_pc;

    // Core side: issues, broadcasts and queries.
    modport master (
        output issue_ready, issue_rd, issue_is_branch, issue_pred_jump, issue_pc,
        output ex_valid, ex_rob_index, ex_val, ex_jump, ex_jump_pc,
        output dc_rs1_depend, dc_rs2_depend,
        input  rob_next_index, rob_full,
        input  rob_rs1_ready, rob_rs2_ready, rob_rs1_val, rob_rs2_val,
        input  rob_to_reg_commit, rob_to_reg_rob_index, rob_to_reg_index, rob_to_reg_val,
        input  rob_clr_out, rob_target_pc
    );

    // Reorder buffer side.
    modport slave (
        input  issue_ready, issue_rd, issue_is_branch, issue_pred_jump, issue_pc,
        input  ex_valid, ex_rob_index, ex_val, ex_jump, ex_jump_pc,
        input  dc_rs1_depend, dc_rs2_depend,
        output rob_next_index, rob_full,
        output rob_rs1_ready, rob_rs2_ready, rob_rs1_val, rob_rs2_val,
        output rob_to_reg_commit, rob_to_reg_rob_index, rob_to_reg_index, rob_to_reg_val,
        output rob_clr_out, rob_target_pc
    );

endinterface

// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - in-order retirement queue with result capture, operand forwarding and mispredict flush
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    reorder_buffer_if.slave  rob
);

    logic [ROB_SIZE-1:0] busy_q;
    logic [ROB_SIZE-1:0] ready_q;
    logic [ROB_SIZE-1:0] is_branch_q;
    logic [ROB_SIZE-1:0] pred_jump_q;
    logic [ROB_SIZE-1:0] jump_q;
    reg_idx_t            rd_q      [ROB_SIZE];
    addr_t               pc_q      [ROB_SIZE];
    data_t               val_q     [ROB_SIZE];
    addr_t               jump_pc_q [ROB_SIZE];

    rob_idx_t head_q;
    rob_idx_t tail_q;
    rob_idx_t count_q;

    logic full_w;
    logic do_commit;
    logic mispredict;
    logic do_issue;
    logic do_capture;

    assign full_w     = (count_q == rob_idx_t'(ROB_USABLE));
    assign do_commit  = (count_q != '0) && busy_q[head_q] && ready_q[head_q];
    assign mispredict = do_commit && is_branch_q[head_q] && (jump_q[head_q] != pred_jump_q[head_q]);
    // An issue on the flush edge belongs to the wrong path and is dropped.
    assign do_issue   = rob.issue_ready && !full_w && !mispredict;
    assign do_capture = rob.ex_valid && busy_q[rob.ex_rob_index];

    assign rob.rob_full       = full_w;
    assign rob.rob_next_index = tail_q;

    // Operand lookup: a same-cycle broadcast wins over the stored entry.
    always_comb begin
        rob.rob_rs1_ready = 1'b0;
        rob.rob_rs1_val   = '0;
        rob.rob_rs2_ready = 1'b0;
        rob.rob_rs2_val   = '0;
        if (rob.dc_rs1_depend != '0) begin
            if (rob.ex_valid && rob.ex_rob_index == rob.dc_rs1_depend) begin
                rob.rob_rs1_ready = 1'b1;
                rob.rob_rs1_val   = rob.ex_val;
            end else begin
                rob.rob_rs1_ready = ready_q[rob.dc_rs1_depend];
                rob.rob_rs1_val   = val_q[rob.dc_rs1_depend];
            end
        end
        if (rob.dc_rs2_depend != '0) begin
            if (rob.ex_valid && rob.ex_rob_index == rob.dc_rs2_depend) begin
                rob.rob_rs2_ready = 1'b1;
                rob.rob_rs2_val   = rob.ex_val;
            end else begin
                rob.rob_rs2_ready = ready_q[rob.dc_rs2_depend];
                rob.rob_rs2_val   = val_q[rob.dc_rs2_depend];
            end
        end
    end

    // Allocation, result capture, retirement and flush; everything holds while rdy_in is low.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head_q                   <= ROB_FIRST_TAG;
            tail_q                   <= ROB_FIRST_TAG;
            count_q                  <= '0;
            busy_q                   <= '0;
            ready_q                  <= '0;
            rob.rob_to_reg_commit    <= 1'b0;
            rob.rob_to_reg_rob_index <= '0;
            rob.rob_to_reg_index     <= '0;
            rob.rob_to_reg_val       <= '0;
            rob.rob_clr_out          <= 1'b0;
            rob.rob_target_pc        <= '0;
        end else if (rdy_in) begin
            rob.rob_to_reg_commit <= 1'b0;
            rob.rob_clr_out       <= 1'b0;

            if (do_issue) begin
                busy_q[tail_q]      <= 1'b1;
                ready_q[tail_q]     <= 1'b0;
                rd_q[tail_q]        <= rob.issue_rd;
                is_branch_q[tail_q] <= rob.issue_is_branch;
                pred_jump_q[tail_q] <= rob.issue_pred_jump;
                pc_q[tail_q]        <= rob.issue_pc;
                tail_q              <= rob_idx_next(tail_q);
            end

            if (do_capture) begin
                ready_q[rob.ex_rob_index]   <= 1'b1;
                val_q[rob.ex_rob_index]     <= rob.ex_val;
                jump_q[rob.ex_rob_index]    <= rob.ex_jump;
                jump_pc_q[rob.ex_rob_index] <= rob.ex_jump_pc;
            end

            if (do_commit) begin
                rob.rob_to_reg_commit    <= 1'b1;
                rob.rob_to_reg_rob_index <= head_q;
                rob.rob_to_reg_index     <= is_branch_q[head_q] ? reg_idx_t'(0) : rd_q[head_q];
                rob.rob_to_reg_val       <= val_q[head_q];
                busy_q[head_q]           <= 1'b0;
                head_q                   <= rob_idx_next(head_q);
            end

            if (do_issue && !do_commit) begin
                count_q <= count_q + rob_idx_t'(1);
            end else if (!do_issue && do_commit) begin
                count_q <= count_q - rob_idx_t'(1);
            end

            // Mispredict overrides the bookkeeping above: the whole window is discarded.
            if (mispredict) begin
                rob.rob_clr_out   <= 1'b1;
                rob.rob_target_pc <= jump_q[head_q] ? jump_pc_q[head_q] : pc_q[head_q] + 32'd4;
                head_q            <= ROB_FIRST_TAG;
                tail_q            <= ROB_FIRST_TAG;
                count_q           <= '0;
                busy_q            <= '0;
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - self-checking bench for reorder_buffer against a queue-based reference model
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    logic clk_in = 1'b0;
    logic rst_in;
    logic rdy_in;
    bit   chk_en = 1'b0;
    int   checks = 0;
    int   failures = 0;

    reorder_buffer_if bus();

    reorder_buffer dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .rob    (bus)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [3:0]  tag;
        logic [4:0]  rd;
        logic        br;
        logic        pred;
        logic [31:0] pc;
        logic        rdy;
        logic [31:0] val;
        logic        jmp;
        logic [31:0] jpc;
    } ent_t;

    ent_t        q[$];
    logic        tag_ready [16];
    logic [31:0] tag_val   [16];
    logic [3:0]  m_tail;
    logic        e_commit, e_clr;
    logic [3:0]  e_idx;
    logic [4:0]  e_reg;
    logic [31:0] e_val, e_tgt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_step();
        ent_t h;
        bit   c, mis, iss;
        if (rst_in) begin
            q.delete();
            m_tail = 4'd1;
            for (int i = 0; i < 16; i++) begin
                tag_ready[i] = 1'b0;
                tag_val[i]   = '0;
            end
            e_commit = 0; e_clr = 0; e_idx = 0; e_reg = 0; e_val = 0; e_tgt = 0;
            return;
        end
        if (!rdy_in) return;
        e_commit = 0;
        e_clr    = 0;
        c   = (q.size() > 0) && q[0].rdy;
        if (c) h = q[0];
        mis = c && h.br && (h.jmp != h.pred);
        iss = bus.issue_ready && (q.size() < 15) && !mis;
        if (bus.ex_valid) begin
            foreach (q[i]) begin
                if (q[i].tag == bus.ex_rob_index) begin
                    q[i].rdy = 1'b1;
                    q[i].val = bus.ex_val;
                    q[i].jmp = bus.ex_jump;
                    q[i].jpc = bus.ex_jump_pc;
                    tag_ready[q[i].tag] = 1'b1;
                    tag_val[q[i].tag]   = bus.ex_val;
                end
            end
        end
        if (c) begin
            void'(q.pop_front());
            e_commit = 1;
            e_idx    = h.tag;
            e_reg    = h.br ? 5'd0 : h.rd;
            e_val    = h.val;
        end
        if (mis) begin
            q.delete();
            m_tail = 4'd1;
            e_clr  = 1;
            e_tgt  = h.jmp ? h.jpc : h.pc + 32'd4;
        end
        if (iss) begin
            q.push_back('{tag: m_tail, rd: bus.issue_rd, br: bus.issue_is_branch,
                          pred: bus.issue_pred_jump, pc: bus.issue_pc, rdy: 1'b0,
                          val: 32'd0, jmp: 1'b0, jpc: 32'd0});
            tag_ready[m_tail] = 1'b0;
            m_tail = (m_tail == 4'd15) ? 4'd1 : m_tail + 4'd1;
        end
    endfunction

    task automatic qry(input string name, input logic [3:0] dep, input logic act_r, input logic [31:0] act_v);
        logic        er;
        logic [31:0] ev;
        if (dep == 4'd0) begin
            er = 0; ev = 0;
        end else if (bus.ex_valid && bus.ex_rob_index == dep) begin
            er = 1; ev = bus.ex_val;
        end else begin
            er = tag_ready[dep]; ev = tag_val[dep];
        end
        chk({name, "_ready"}, act_r, er);
        if (er || dep == 4'd0) chk({name, "_val"}, act_v, ev);
    endtask

    // Every cycle: all outputs against the reference model.
    always @(negedge clk_in) begin
        if (chk_en) begin
            chk("commit",     bus.rob_to_reg_commit,    e_commit);
            chk("commit_tag", bus.rob_to_reg_rob_index, e_idx);
            chk("commit_reg", bus.rob_to_reg_index,     e_reg);
            chk("commit_val", bus.rob_to_reg_val,       e_val);
            chk("clr",        bus.rob_clr_out,          e_clr);
            chk("target_pc",  bus.rob_target_pc,        e_tgt);
            chk("full",       bus.rob_full,             q.size() == 15);
            chk("next_index", bus.rob_next_index,       m_tail);
            qry("rs1", bus.dc_rs1_depend, bus.rob_rs1_ready, bus.rob_rs1_val);
            qry("rs2", bus.dc_rs2_depend, bus.rob_rs2_ready, bus.rob_rs2_val);
        end
    end

    task automatic idle();
        bus.issue_ready = 0; bus.issue_rd = 0; bus.issue_is_branch = 0;
        bus.issue_pred_jump = 0; bus.issue_pc = 0;
        bus.ex_valid = 0; bus.ex_rob_index = 0; bus.ex_val = 0;
        bus.ex_jump = 0; bus.ex_jump_pc = 0;
        bus.dc_rs1_depend = 0; bus.dc_rs2_depend = 0;
    endtask

    task automatic cyc();
        @(posedge clk_in);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst_in = 1; rdy_in = 1;
        idle();
        cyc(); cyc();
        rst_in = 0;
        chk_en = 1;
    endtask

    task automatic issue(input logic [4:0] rd, input logic br, input logic pred, input logic [31:0] pc);
        bus.issue_ready = 1; bus.issue_rd = rd; bus.issue_is_branch = br;
        bus.issue_pred_jump = pred; bus.issue_pc = pc;
    endtask

    task automatic bcast(input logic [3:0] tag, input logic [31:0] v, input logic j, input logic [31:0] jpc);
        bus.ex_valid = 1; bus.ex_rob_index = tag; bus.ex_val = v;
        bus.ex_jump = j; bus.ex_jump_pc = jpc;
    endtask

    initial begin
        rst_in = 1; rdy_in = 1;
        idle();
        do_reset();
        chk("rst_next_index", bus.rob_next_index, 32'd1);
        chk("rst_commit", bus.rob_to_reg_commit, 32'd0);
        chk("rst_full", bus.rob_full, 32'd0);

        // Single issue/broadcast/commit
        issue(5'd5, 0, 0, 32'h40); cyc(); idle();
        chk("s1_next_index", bus.rob_next_index, 32'd2);
        bcast(4'd1, 32'h1234, 0, 0); cyc(); idle();
        chk("s1_no_early_commit", bus.rob_to_reg_commit, 32'd0);
        cyc();
        chk("s1_commit", bus.rob_to_reg_commit, 32'd1);
        chk("s1_tag", bus.rob_to_reg_rob_index, 32'd1);
        chk("s1_reg", bus.rob_to_reg_index, 32'd5);
        chk("s1_val", bus.rob_to_reg_val, 32'h1234);
        cyc();
        chk("s1_pulse_end", bus.rob_to_reg_commit, 32'd0);

        // Fill to 15, overflow ignored, wrap skips tag 0
        do_reset();
        for (int i = 0; i < 15; i++) begin
            issue(5'(i + 1), 0, 0, 32'h1000 + 32'(i * 4)); cyc();
        end
        chk("s2_full", bus.rob_full, 32'd1);
        chk("s2_wrap_tail", bus.rob_next_index, 32'd1);
        cyc(); idle();
        chk("s2_overflow_full", bus.rob_full, 32'd1);
        chk("s2_overflow_tail", bus.rob_next_index, 32'd1);
        bcast(4'd1, 32'h7, 0, 0); cyc(); idle(); cyc();
        chk("s2_commit_tag", bus.rob_to_reg_rob_index, 32'd1);
        chk("s2_not_full", bus.rob_full, 32'd0);
        issue(5'd9, 0, 0, 32'h2000); cyc(); idle();
        chk("s2_refill_tail", bus.rob_next_index, 32'd2);
        chk("s2_refull", bus.rob_full, 32'd1);

        // Out-of-order completion retires in order
        do_reset();
        for (int i = 0; i < 3; i++) begin
            issue(5'(i + 10), 0, 0, 32'h300 + 32'(i * 4)); cyc();
        end
        idle();
        bcast(4'd3, 32'h33, 0, 0); cyc();
        bcast(4'd2, 32'h22, 0, 0); cyc();
        bcast(4'd1, 32'h11, 0, 0); cyc(); idle();
        chk("s3_wait", bus.rob_to_reg_commit, 32'd0);
        cyc(); chk("s3_first", bus.rob_to_reg_rob_index, 32'd1);
        cyc(); chk("s3_second", bus.rob_to_reg_rob_index, 32'd2);
               chk("s3_second_val", bus.rob_to_reg_val, 32'h22);
        cyc(); chk("s3_third", bus.rob_to_reg_rob_index, 32'd3);
               chk("s3_third_pulse", bus.rob_to_reg_commit, 32'd1);

        // Mispredicted branch flush, with a discarded issue on the flush edge
        do_reset();
        issue(5'd7, 1, 0, 32'h100); cyc(); idle();
        bcast(4'd1, 32'h0, 1, 32'h200); cyc(); idle();
        issue(5'd4, 0, 0, 32'h500); cyc(); idle();
        chk("s4_clr", bus.rob_clr_out, 32'd1);
        chk("s4_target", bus.rob_target_pc, 32'h200);
        chk("s4_branch_reg", bus.rob_to_reg_index, 32'd0);
        chk("s4_next_index", bus.rob_next_index, 32'd1);
        cyc();
        chk("s4_clr_end", bus.rob_clr_out, 32'd0);
        chk("s4_empty_tail", bus.rob_next_index, 32'd1);

        // Forwarding from a same-cycle broadcast, tag 0 never ready
        do_reset();
        for (int i = 0; i < 4; i++) begin
            issue(5'(i + 1), 0, 0, 32'h600 + 32'(i * 4)); cyc();
        end
        idle();
        bcast(4'd4, 32'hAB, 0, 0);
        bus.dc_rs1_depend = 4'd4; bus.dc_rs2_depend = 4'd0;
        #1;
        chk("s5_fwd_ready", bus.rob_rs1_ready, 32'd1);
        chk("s5_fwd_val", bus.rob_rs1_val, 32'hAB);
        chk("s5_tag0_ready", bus.rob_rs2_ready, 32'd0);
        cyc(); idle();
        bus.dc_rs1_depend = 4'd4; #1;
        chk("s5_stored_val", bus.rob_rs1_val, 32'hAB);

        // rdy_in low freezes a registered commit pulse and blocks issue
        do_reset();
        issue(5'd3, 0, 0, 32'h700); cyc(); idle();
        bcast(4'd1, 32'h55, 0, 0); cyc(); idle(); cyc();
        rdy_in = 0;
        issue(5'd6, 0, 0, 32'h704);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("s6_hold_commit", bus.rob_to_reg_commit, 32'd1);
            chk("s6_hold_val", bus.rob_to_reg_val, 32'h55);
            chk("s6_hold_tail", bus.rob_next_index, 32'd2);
        end
        rdy_in = 1; idle(); cyc();
        chk("s6_release", bus.rob_to_reg_commit, 32'd0);

        // Randomized traffic against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            idle();
            rst_in = ($urandom_range(0, 499) == 0);
            rdy_in = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 1) == 1)
                issue(5'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom),
                      $urandom() & 32'hFFFF_FFFC);
            if ($urandom_range(0, 9) < 6) begin
                if (q.size() > 0 && $urandom_range(0, 3) != 0) begin
                    int k;
                    k = $urandom_range(0, q.size() - 1);
                    bcast(q[k].tag, $urandom(),
                          ($urandom_range(0, 4) == 0) ? !q[k].pred : q[k].pred,
                          $urandom() & 32'hFFFF_FFFC);
                end else begin
                    bcast(4'($urandom), $urandom(), 1'($urandom), $urandom());
                end
            end
            bus.dc_rs1_depend = 4'($urandom);
            bus.dc_rs2_depend = 4'($urandom);
            cyc();
        end
        rst_in = 0; rdy_in = 1; idle();
        cyc(); cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
